// File: rtl/sram_nr1w_be_pkg.sv
// Shared types and helpers for the multi-read-port byte-enable SRAM.
package sram_nr1w_be_pkg;

    localparam int unsigned LaneWidth = 8;

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StReady = 1'b1
    } clr_state_e;

    function automatic int unsigned num_lanes(input int unsigned data_width);
        return data_width / LaneWidth;
    endfunction

endpackage

// File: rtl/sram_nr1w_be_if.sv
// Bus bundle for sram_nr1w_be: one byte-enable write port plus N read ports.
interface sram_nr1w_be_if
    import sram_nr1w_be_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SIZE           = 1024,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned ADDR_WIDTH     = $clog2(SIZE)
);

    logic [NUM_READ_PORTS-1:0]    read_en;
    logic [ADDR_WIDTH-1:0]        read_addr [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0]        read_data [NUM_READ_PORTS];
    logic                         write_en;
    logic [ADDR_WIDTH-1:0]        write_addr;
    logic [DATA_WIDTH/LaneWidth-1:0] write_byte_en;
    logic [DATA_WIDTH-1:0]        write_data;
    logic                         init_busy;

    modport master (
        output read_en,
        output read_addr,
        output write_en,
        output write_addr,
        output write_byte_en,
        output write_data,
        input  read_data,
        input  init_busy
    );

    modport slave (
        input  read_en,
        input  read_addr,
        input  write_en,
        input  write_addr,
        input  write_byte_en,
        input  write_data,
        output read_data,
        output init_busy
    );

endinterface

// File: rtl/sram_clear_sequencer.sv
// Post-reset zero-fill sequencer: walks every entry once, then parks in READY.
module sram_clear_sequencer
    import sram_nr1w_be_pkg::*;
#(
    parameter int unsigned SIZE           = 1024,
    parameter int unsigned ADDR_WIDTH     = $clog2(SIZE),
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  o_clear_sel,
    output logic [ADDR_WIDTH-1:0] o_clear_addr,
    output logic                  o_ready,
    output logic                  o_init_busy
);

    // One spare bit so the terminal compare works for any SIZE, power of two or not.
    localparam logic [ADDR_WIDTH:0] LastAddr   = (ADDR_WIDTH + 1)'(SIZE - 1);
    localparam clr_state_e          ResetState = CLEAR_ON_RESET ? StClear : StReady;

    clr_state_e          r_state;
    clr_state_e          w_state_next;
    logic [ADDR_WIDTH:0] r_clear_addr;
    logic [ADDR_WIDTH:0] w_clear_addr_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ResetState;
            r_clear_addr <= '0;
        end else begin
            r_state      <= w_state_next;
            r_clear_addr <= w_clear_addr_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_clear_addr_next = r_clear_addr;
        case (r_state)
            StClear: begin
                if (r_clear_addr == LastAddr) begin
                    w_state_next = StReady;
                end else begin
                    w_clear_addr_next = r_clear_addr + (ADDR_WIDTH + 1)'(1);
                end
            end
            StReady: w_state_next = StReady;
            default: w_state_next = ResetState;
        endcase
    end

    always_comb begin
        o_clear_sel  = (r_state == StClear);
        o_init_busy  = (r_state == StClear);
        o_ready      = (r_state == StReady);
        o_clear_addr = r_clear_addr[ADDR_WIDTH-1:0];
    end

endmodule

// File: rtl/sram_nr1w_be.sv
// Synchronous SRAM, one byte-enable write port, NUM_READ_PORTS registered read ports,
// optional post-reset zero fill and same-cycle write-to-read bypass.
module sram_nr1w_be
    import sram_nr1w_be_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned SIZE              = 1024,
    parameter int unsigned NUM_READ_PORTS    = 2,
    parameter string       READ_DURING_WRITE = "NEW_DATA",
    parameter bit          CLEAR_ON_RESET    = 1'b1,
    parameter int unsigned ADDR_WIDTH        = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    sram_nr1w_be_if.slave io_bus
);

    localparam int unsigned NumLanes  = num_lanes(DATA_WIDTH);
    localparam bit          BypassNew = (READ_DURING_WRITE == "NEW_DATA");

    logic                  w_clear_sel;
    logic                  w_ready;
    logic                  w_init_busy;
    logic [ADDR_WIDTH-1:0] w_clear_addr;

    logic                  w_user_we;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [NumLanes-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_wdata;

    logic [DATA_WIDTH-1:0] r_mem     [SIZE];
    logic [DATA_WIDTH-1:0] r_rdata   [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0] w_rd_next [NUM_READ_PORTS];

    sram_clear_sequencer #(
        .SIZE           (SIZE),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk          (clk),
        .reset        (reset),
        .o_clear_sel  (w_clear_sel),
        .o_clear_addr (w_clear_addr),
        .o_ready      (w_ready),
        .o_init_busy  (w_init_busy)
    );

    // Sequencer owns the write port while clearing; user writes only land once READY.
    always_comb begin
        w_user_we = w_ready && io_bus.write_en && !reset;
        w_we      = (w_clear_sel && !reset) || w_user_we;
        w_waddr   = w_clear_sel ? w_clear_addr : io_bus.write_addr;
        w_be      = w_clear_sel ? '1 : io_bus.write_byte_en;
        w_wdata   = w_clear_sel ? '0 : io_bus.write_data;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < NumLanes; i++) begin
                if (w_be[i]) begin
                    r_mem[w_waddr][LaneWidth*i +: LaneWidth] <= w_wdata[LaneWidth*i +: LaneWidth];
                end
            end
        end
    end

    // Per-port bypass: enabled write lanes override the stale array word on a collision.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            w_rd_next[p] = r_mem[io_bus.read_addr[p]];
            if (w_user_we && (io_bus.read_addr[p] == io_bus.write_addr)) begin
                if (BypassNew) begin
                    for (int i = 0; i < NumLanes; i++) begin
                        if (io_bus.write_byte_en[i]) begin
                            w_rd_next[p][LaneWidth*i +: LaneWidth] =
                                io_bus.write_data[LaneWidth*i +: LaneWidth];
                        end
                    end
                end else begin
                    w_rd_next[p] = 'x;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                r_rdata[p] <= '0;
            end
        end else if (w_ready) begin
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (io_bus.read_en[p]) begin
                    r_rdata[p] <= w_rd_next[p];
                end
            end
        end
    end

    assign io_bus.read_data = r_rdata;
    assign io_bus.init_busy = w_init_busy;

endmodule

// File: tb/tb_sram_nr1w_be.sv
// Self-checking bench for sram_nr1w_be: a NEW_DATA/clear-on-reset instance against
// an array model, plus a DONT_CARE/no-clear instance with directed checks.
module tb_sram_nr1w_be;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m  [16];
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    sram_nr1w_be_if #(.DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(2)) bus_a ();
    sram_nr1w_be_if #(.DATA_WIDTH(32), .SIZE(16), .NUM_READ_PORTS(2)) bus_b ();

    sram_nr1w_be #(
        .DATA_WIDTH        (32),
        .SIZE              (16),
        .NUM_READ_PORTS    (2),
        .READ_DURING_WRITE ("NEW_DATA"),
        .CLEAR_ON_RESET    (1'b1)
    ) u_dut_a (
        .clk    (clk),
        .reset  (rst_a),
        .io_bus (bus_a)
    );

    sram_nr1w_be #(
        .DATA_WIDTH        (32),
        .SIZE              (16),
        .NUM_READ_PORTS    (2),
        .READ_DURING_WRITE ("DONT_CARE"),
        .CLEAR_ON_RESET    (1'b0)
    ) u_dut_b (
        .clk    (clk),
        .reset  (rst_b),
        .io_bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
    endtask

    task automatic drive_a(input logic [1:0] ren, input logic [3:0] ra0, input logic [3:0] ra1,
                           input logic we, input logic [3:0] wa, input logic [3:0] be,
                           input logic [31:0] wd);
        bus_a.read_en       = ren;
        bus_a.read_addr[0]  = ra0;
        bus_a.read_addr[1]  = ra1;
        bus_a.write_en      = we;
        bus_a.write_addr    = wa;
        bus_a.write_byte_en = be;
        bus_a.write_data    = wd;
    endtask

    // One READY cycle on A; a read sees the array as it stands after this cycle's write.
    task automatic step_a(input logic [1:0] ren, input logic [3:0] ra0, input logic [3:0] ra1,
                          input logic we, input logic [3:0] wa, input logic [3:0] be,
                          input logic [31:0] wd);
        drive_a(ren, ra0, ra1, we, wa, be, wd);
        @(posedge clk);
        #1;
        if (we) mem_m[wa] = apply_be(mem_m[wa], wd, be);
        if (ren[0]) exp_rd[0] = mem_m[ra0];
        if (ren[1]) exp_rd[1] = mem_m[ra1];
        check("a_rd0", bus_a.read_data[0], exp_rd[0]);
        check("a_rd1", bus_a.read_data[1], exp_rd[1]);
        check("a_busy_ready", 32'(bus_a.init_busy), 32'h0);
    endtask

    // Called right after reset release; hammers reads and a write that must be ignored.
    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        drive_a(2'b11, 4'd9, 4'd0, 1'b1, 4'd0, 4'hF, 32'hDEADBEEF);
        while (bus_a.init_busy && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'd16);
        check({tag, "_rd0_clear"}, bus_a.read_data[0], 32'h0);
        check({tag, "_rd1_clear"}, bus_a.read_data[1], 32'h0);
        drive_a(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        model_clear();
    endtask

    task automatic drive_b(input logic [1:0] ren, input logic [3:0] ra0, input logic [3:0] ra1,
                           input logic we, input logic [3:0] wa, input logic [3:0] be,
                           input logic [31:0] wd);
        bus_b.read_en       = ren;
        bus_b.read_addr[0]  = ra0;
        bus_b.read_addr[1]  = ra1;
        bus_b.write_en      = we;
        bus_b.write_addr    = wa;
        bus_b.write_byte_en = be;
        bus_b.write_data    = wd;
    endtask

    initial begin
        drive_a(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        drive_b(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        model_clear();

        // Reset state of A
        @(posedge clk);
        #1;
        check("a_rst_rd0", bus_a.read_data[0], 32'h0);
        check("a_rst_rd1", bus_a.read_data[1], 32'h0);
        check("a_rst_busy", 32'(bus_a.init_busy), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        wait_clear("clr1");

        // Whole array reads zero on both ports
        for (int a = 0; a < 16; a++) step_a(2'b11, 4'(a), 4'(15 - a), 1'b0, 4'd0, 4'h0, 32'h0);

        // Byte enables
        step_a(2'b00, 4'd0, 4'd0, 1'b1, 4'd5, 4'b1111, 32'hAABBCCDD);
        step_a(2'b00, 4'd0, 4'd0, 1'b1, 4'd5, 4'b0101, 32'h11223344);
        step_a(2'b01, 4'd5, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        check("a_be_merge", bus_a.read_data[0], 32'hAA22CC44);

        // Same-cycle collision on both ports
        step_a(2'b00, 4'd0, 4'd0, 1'b1, 4'd3, 4'b1111, 32'h12345678);
        step_a(2'b11, 4'd3, 4'd3, 1'b1, 4'd3, 4'b1100, 32'hFFFFFFFF);
        check("a_coll_p0", bus_a.read_data[0], 32'hFFFF5678);
        check("a_coll_p1", bus_a.read_data[1], 32'hFFFF5678);

        // Independent ports and hold on read_en=0
        step_a(2'b00, 4'd0, 4'd0, 1'b1, 4'd1, 4'b1111, 32'h1);
        step_a(2'b00, 4'd0, 4'd0, 1'b1, 4'd2, 4'b1111, 32'h2);
        step_a(2'b11, 4'd1, 4'd2, 1'b0, 4'd0, 4'h0, 32'h0);
        step_a(2'b01, 4'd2, 4'd1, 1'b0, 4'd0, 4'h0, 32'h0);
        check("a_indep_p0", bus_a.read_data[0], 32'h2);
        check("a_indep_p1_hold", bus_a.read_data[1], 32'h2);

        // Randomised traffic against the array model
        for (int n = 0; n < 400; n++) begin
            step_a(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'($urandom));
        end

        // Reset while READY, then again mid-clear
        step_a(2'b00, 4'd0, 4'd0, 1'b1, 4'd9, 4'b1111, 32'hCAFEF00D);
        step_a(2'b11, 4'd9, 4'd9, 1'b0, 4'd0, 4'h0, 32'h0);
        drive_a(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
        rst_a = 1'b1;
        #1;
        check("a_async_rd0", bus_a.read_data[0], 32'h0);
        check("a_async_rd1", bus_a.read_data[1], 32'h0);
        check("a_async_busy", 32'(bus_a.init_busy), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("a_midclr_busy", 32'(bus_a.init_busy), 32'h1);
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        wait_clear("clr2");
        for (int a = 0; a < 16; a++) step_a(2'b11, 4'(a), 4'(15 - a), 1'b0, 4'd0, 4'h0, 32'h0);

        // DONT_CARE instance without clear
        check("b_rst_busy", 32'(bus_b.init_busy), 32'h0);
        check("b_rst_rd0", bus_b.read_data[0], 32'h0);
        drive_b(2'b00, 4'd0, 4'd0, 1'b1, 4'd4, 4'b1111, 32'h89ABCDEF);
        rst_b = 1'b0;
        #1;
        check("b_busy_release", 32'(bus_b.init_busy), 32'h0);
        @(posedge clk);
        #1;
        drive_b(2'b00, 4'd0, 4'd0, 1'b1, 4'd7, 4'b1111, 32'h0BADCAFE);
        @(posedge clk);
        #1;
        drive_b(2'b11, 4'd4, 4'd4, 1'b0, 4'd0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        check("b_first_write_p0", bus_b.read_data[0], 32'h89ABCDEF);
        check("b_first_write_p1", bus_b.read_data[1], 32'h89ABCDEF);
        // Port 0 collides (value unchecked), port 1 reads elsewhere
        drive_b(2'b11, 4'd4, 4'd7, 1'b1, 4'd4, 4'b0011, 32'h0);
        @(posedge clk);
        #1;
        check("b_coll_other_port", bus_b.read_data[1], 32'h0BADCAFE);
        drive_b(2'b11, 4'd4, 4'd4, 1'b0, 4'd0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        check("b_after_coll_p0", bus_b.read_data[0], 32'h89AB0000);
        check("b_after_coll_p1", bus_b.read_data[1], 32'h89AB0000);
        check("b_busy_end", 32'(bus_b.init_busy), 32'h0);
        drive_b(2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
